metadata_server: RTL and testbench

// - Responder end of the per-lane metadata request/available/link interface consumed by SC_block.
// - Buffers 16-bit note-metadata words written by the song loader (SD path in CL_block) in per-lane circular queues.
// - Presents each lane's head word on its link slice with an available flag; pops it when the consumer requests.

---
 rtl/metadata_server_pkg.sv | 22 ++
 rtl/metadata_server_rr_arbiter.sv | 28 ++
 rtl/metadata_server.sv | 126 ++++++++++++
 tb/tb_metadata_server.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/metadata_server_pkg.sv
// Shared sizing, FSM encoding and helpers for the per-lane metadata server.
package metadata_server_pkg;
  localparam int LANES  = 37;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = 6;
  localparam int ADDR_W = LANE_W + PTR_W;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_LOAD = 1'b1
  } fill_state_e;

  function automatic logic [5:0] popcount(input logic [LANES-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/metadata_server_rr_arbiter.sv
// Round-robin pick over the lane request vector, searching upward from the lane after the last grant.
module metadata_server_rr_arbiter
  import metadata_server_pkg::*;
(
  input  logic [LANES-1:0]  i_req,
  input  logic [LANE_W-1:0] i_last,
  output logic [LANES-1:0]  o_grant_oh,
  output logic [LANE_W-1:0] o_grant_idx,
  output logic              o_valid
);
  logic [LANE_W-1:0] w_idx;

  // Walk from farthest to nearest so the nearest requester after i_last wins.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_idx       = '0;
    for (int k = LANES; k >= 1; k--) begin
      w_idx = LANE_W'((int'(i_last) + k) % LANES);
      if (i_req[w_idx]) begin
        o_valid     = 1'b1;
        o_grant_idx = w_idx;
        o_grant_oh  = LANES'(1) << w_idx;
      end
    end
  end
endmodule

// File: rtl/metadata_server.sv
// Per-lane circular metadata queues in one shared RAM, with a refill FSM feeding each lane's head/link slice.
// state | meaning
// SCAN  | pick next eligible lane round-robin, issue RAM read of its oldest word
// LOAD  | RAM word lands in the lane's link slice, lane marked available
module metadata_server
  import metadata_server_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_pause,
  input  logic                   i_wr_valid,
  input  logic [LANE_W-1:0]      i_wr_lane,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_wr_ready,
  input  logic [LANES-1:0]       i_metadata_request,
  output logic [LANES*WIDTH-1:0] o_metadata_link,
  output logic [LANES-1:0]       o_metadata_available,
  output logic [15:0]            o_underrun_count
);
  logic [WIDTH-1:0]       r_mem [LANES*DEPTH];
  logic [WIDTH-1:0]       r_rd_data;
  logic [PTR_W-1:0]       r_wr_ptr [LANES];
  logic [PTR_W-1:0]       r_rd_ptr [LANES];
  logic [CNT_W-1:0]       r_cnt [LANES];
  logic [LANES-1:0]       r_avail;
  logic [LANES*WIDTH-1:0] r_link;
  logic [15:0]            r_underrun;
  fill_state_e            r_state;
  logic [LANE_W-1:0]      r_load_lane;
  logic [LANE_W-1:0]      r_rr;

  logic                   w_lane_ok;
  logic                   w_wr_fire;
  logic                   w_issue;
  logic [LANES-1:0]       w_eligible;
  logic [LANES-1:0]       w_grant_oh;
  logic [LANE_W-1:0]      w_grant_idx;
  logic                   w_grant_valid;
  logic [LANES-1:0]       w_inc;
  logic [LANES-1:0]       w_dec;
  logic [LANES-1:0]       w_consume;
  logic [LANES-1:0]       w_underrun;
  logic [LANES-1:0]       w_load_set;
  logic [16:0]            w_underrun_sum;
  logic [ADDR_W-1:0]      w_waddr;
  logic [ADDR_W-1:0]      w_raddr;

  assign w_lane_ok  = (i_wr_lane < LANE_W'(LANES));
  assign o_wr_ready = w_lane_ok && (r_cnt[i_wr_lane] != CNT_W'(DEPTH)) && !i_flush;
  assign w_wr_fire  = i_wr_valid && o_wr_ready;

  // A lane whose word is already on its way from RAM must not be picked twice.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < LANES; i++)
      w_eligible[i] = !r_avail[i] && (r_cnt[i] != '0) &&
                      !((r_state == ST_LOAD) && (r_load_lane == LANE_W'(i)));
  end

  metadata_server_rr_arbiter u_arb (
    .i_req       (w_eligible),
    .i_last      (r_rr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_valid     (w_grant_valid)
  );

  assign w_issue        = (r_state == ST_SCAN) && w_grant_valid;
  assign w_inc          = w_wr_fire ? (LANES'(1) << i_wr_lane) : '0;
  assign w_dec          = w_issue ? w_grant_oh : '0;
  assign w_consume      = i_metadata_request & r_avail & {LANES{!i_pause}};
  assign w_underrun     = i_metadata_request & ~r_avail & {LANES{!i_pause}};
  assign w_load_set     = (r_state == ST_LOAD) ? (LANES'(1) << r_load_lane) : '0;
  assign w_underrun_sum = {1'b0, r_underrun} + 17'(popcount(w_underrun));
  assign w_waddr        = {i_wr_lane, r_wr_ptr[i_wr_lane]};
  assign w_raddr        = {w_grant_idx, r_rd_ptr[w_grant_idx]};

  // Plain simple-dual-port RAM, no reset, no output register.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) r_mem[w_waddr] <= i_wr_data;
    if (w_issue)   r_rd_data <= r_mem[w_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      for (int i = 0; i < LANES; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_avail     <= '0;
      r_link      <= '0;
      r_underrun  <= '0;
      r_state     <= ST_SCAN;
      r_load_lane <= '0;
      r_rr        <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_inc[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_dec[i]) r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
      end
      r_avail    <= (r_avail & ~w_consume) | w_load_set;
      r_underrun <= w_underrun_sum[16] ? 16'hFFFF : w_underrun_sum[15:0];
      case (r_state)
        ST_SCAN: begin
          if (w_grant_valid) begin
            r_load_lane <= w_grant_idx;
            r_rr        <= w_grant_idx;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_link[r_load_lane*WIDTH +: WIDTH] <= r_rd_data;
          r_state <= ST_SCAN;
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign o_metadata_link      = r_link;
  assign o_metadata_available = r_avail;
  assign o_underrun_count     = r_underrun;
endmodule

// File: tb/tb_metadata_server.sv
// Scoreboard bench for metadata_server: stimulus pushes accepted words into per-lane expected
// queues; a negedge monitor pops and compares whenever a lane head is consumed.
module tb_metadata_server;
  import metadata_server_pkg::*;

  logic                   clk      = 1'b0;
  logic                   reset    = 1'b1;
  logic                   flush    = 1'b0;
  logic                   pause    = 1'b0;
  logic                   wr_valid = 1'b0;
  logic [LANE_W-1:0]      wr_lane  = '0;
  logic [WIDTH-1:0]       wr_data  = '0;
  logic [LANES-1:0]       req      = '0;
  logic                   wr_ready;
  logic [LANES*WIDTH-1:0] link;
  logic [LANES-1:0]       avail;
  logic [15:0]            underrun;

  metadata_server dut (
    .i_clk                (clk),
    .i_reset              (reset),
    .i_flush              (flush),
    .i_pause              (pause),
    .i_wr_valid           (wr_valid),
    .i_wr_lane            (wr_lane),
    .i_wr_data            (wr_data),
    .o_wr_ready           (wr_ready),
    .i_metadata_request   (req),
    .o_metadata_link      (link),
    .o_metadata_available (avail),
    .o_underrun_count     (underrun)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [WIDTH-1:0] exp_q [LANES][$];
  logic [WIDTH-1:0] cons36 [$];
  int unsigned      model_underrun = 0;
  logic             last_accept = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [LANES-1:0] bit_of(input int i);
    return LANES'(1) << i;
  endfunction

  // Monitor: a request meeting an available head (no pause, no clear) pops the model queue.
  always @(negedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < LANES; i++) exp_q[i].delete();
      model_underrun = 0;
    end else if (!pause) begin
      for (int i = 0; i < LANES; i++) begin
        if (req[i] && avail[i]) begin
          check($sformatf("pop_has_word_lane%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0) begin
            if (i == LANES - 1) cons36.push_back(link[i*WIDTH +: WIDTH]);
            check($sformatf("pop_data_lane%0d", i), 64'(link[i*WIDTH +: WIDTH]),
                  64'(exp_q[i].pop_front()));
          end
        end else if (req[i] && model_underrun < 65535) begin
          model_underrun++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle of stimulus; wr_ready is judged against model occupancy (head + queued words).
  task automatic drive(input logic v, input logic [LANE_W-1:0] ln, input logic [WIDTH-1:0] d,
                       input logic [LANES-1:0] rq);
    int occ;
    wr_valid = v; wr_lane = ln; wr_data = d; req = rq;
    last_accept = 1'b0;
    #2;
    if (!reset) begin
      occ = (int'(ln) < LANES) ? exp_q[ln].size() : 0;
      if (flush || int'(ln) >= LANES) check("wr_ready_blocked", 64'(wr_ready), 64'd0);
      else if (occ >= DEPTH + 1)      check("wr_ready_full", 64'(wr_ready), 64'd0);
      else if (occ < DEPTH)           check("wr_ready_room", 64'(wr_ready), 64'd1);
      if (v && wr_ready && !flush && int'(ln) < LANES) begin
        exp_q[ln].push_back(d);
        last_accept = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    req      = '0;
  endtask

  function automatic logic all_empty();
    for (int i = 0; i < LANES; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int guard = 0;
    while (!all_empty() && guard < 400) begin
      drive(1'b0, '0, '0, avail);
      guard++;
    end
    check("drain_done", 64'(all_empty()), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int               next;
    int               guard;
    logic             ok;
    logic [WIDTH-1:0] w;
    logic [LANES-1:0] m;
    logic [LANE_W-1:0] ln;
    int               arb_tab [7] = '{0, 0, 1, 1, 3, 3, 7};

    // Reset held for two edges.
    step(2);
    reset = 1'b0;
    check("rst_avail", 64'(avail), 64'd0);
    check("rst_link_zero", 64'(link == '0), 64'd1);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_wr_ready_lane0", 64'(wr_ready), 64'd1);

    // Single word on lane 5: visible two edges after acceptance.
    drive(1'b1, 6'd5, 16'hBEEF, '0);
    check("single_accept", 64'(last_accept), 64'd1);
    check("single_avail_E", 64'(avail[5]), 64'd0);
    step(1);
    check("single_avail_E1", 64'(avail[5]), 64'd0);
    step(1);
    check("single_avail_E2", 64'(avail[5]), 64'd1);
    check("single_link", 64'(link[95:80]), 64'hBEEF);
    drive(1'b0, 6'd5, '0, bit_of(5));
    check("single_popped", 64'(avail[5]), 64'd0);
    step(10);
    check("single_no_refill", 64'(avail[5]), 64'd0);

    // Fill lane 0: one head plus DEPTH queued, then stall, pop, recover.
    for (int k = 0; k < DEPTH + 1; k++) drive(1'b1, 6'd0, WIDTH'($urandom), '0);
    check("full_nine_accepted", 64'(exp_q[0].size()), 64'(DEPTH + 1));
    step(3);
    drive(1'b1, 6'd0, 16'hDEAD, '0);
    check("full_tenth_stalled", 64'(last_accept), 64'd0);
    drive(1'b0, 6'd0, '0, bit_of(0));
    ok = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (wr_ready) ok = 1'b1;
      if (!ok) step(1);
    end
    check("full_ready_return", 64'(ok), 64'd1);
    drive(1'b1, 6'd0, WIDTH'($urandom), '0);
    check("full_write_after_pop", 64'(last_accept), 64'd1);
    drain();

    // Ordered stream through lane 36 with random consumption, wrapping the queue.
    cons36.delete();
    next  = 1;
    guard = 0;
    while (cons36.size() < 20 && guard < 600) begin
      drive(next <= 20, 6'd36, WIDTH'(next), ($urandom_range(0, 1) != 0) ? bit_of(36) : '0);
      if (last_accept) next++;
      guard++;
    end
    check("order_count", 64'(cons36.size()), 64'd20);
    for (int k = 0; k < cons36.size(); k++)
      check($sformatf("order_word%0d", k), 64'(cons36[k]), 64'(k + 1));

    // Arbitration: end with lane 36 as last grant, then make 0, 1, 36 eligible together.
    flush = 1'b1;
    drive(1'b0, '0, '0, '0);
    flush = 1'b0;
    drive(1'b1, 6'd0, 16'h0A00, '0);
    drive(1'b1, 6'd0, 16'h0A01, '0);
    drive(1'b1, 6'd1, 16'h0B00, '0);
    drive(1'b1, 6'd1, 16'h0B01, '0);
    drive(1'b1, 6'd36, 16'h0C00, '0);
    drive(1'b1, 6'd36, 16'h0C01, '0);
    step(10);
    check("arb_preloaded", 64'({avail[36], avail[1], avail[0]}), 64'd7);
    drive(1'b0, '0, '0, bit_of(0) | bit_of(1) | bit_of(36));
    for (int t = 0; t < 7; t++) begin
      check($sformatf("arb_fill_t%0d", t), 64'({avail[36], avail[1], avail[0]}), 64'(arb_tab[t]));
      if (t < 6) step(1);
    end
    drain();

    // Underrun counting and pause.
    flush = 1'b1;
    drive(1'b0, '0, '0, '0);
    flush = 1'b0;
    drive(1'b0, '0, '0, bit_of(3));
    check("underrun_one", 64'(underrun), 64'd1);
    pause = 1'b1;
    drive(1'b0, '0, '0, bit_of(3));
    pause = 1'b0;
    check("underrun_paused", 64'(underrun), 64'd1);
    drive(1'b1, 6'd3, 16'h3333, '0);
    step(3);
    check("pause_head_ready", 64'(avail[3]), 64'd1);
    pause = 1'b1;
    drive(1'b0, '0, '0, bit_of(3));
    pause = 1'b0;
    check("pause_no_pop", 64'(avail[3]), 64'd1);
    check("pause_underrun_same", 64'(underrun), 64'd1);
    drain();

    // Flush while lane 7 is in LOAD, with a write and request in the same cycle.
    drive(1'b1, 6'd7, 16'h7777, '0);
    step(1);
    flush = 1'b1;
    drive(1'b1, 6'd7, 16'h5555, bit_of(7));
    flush = 1'b0;
    check("flush_avail", 64'(avail), 64'd0);
    check("flush_link_zero", 64'(link == '0), 64'd1);
    check("flush_underrun", 64'(underrun), 64'd0);
    step(4);
    check("flush_load_aborted", 64'(avail), 64'd0);
    drive(1'b1, 6'd7, 16'h1234, '0);
    step(1);
    check("flush_rewrite_E1", 64'(avail[7]), 64'd0);
    step(1);
    check("flush_rewrite_E2", 64'(avail[7]), 64'd1);
    check("flush_rewrite_link", 64'(link[7*WIDTH +: WIDTH]), 64'h1234);
    drain();

    // Out-of-range lanes are never accepted.
    drive(1'b1, 6'd37, 16'hAAAA, '0);
    drive(1'b1, 6'd63, 16'hBBBB, '0);
    step(4);
    check("bad_lane_no_avail", 64'(avail), 64'd0);

    // Randomized traffic with occasional pause, flush and illegal lanes.
    for (int c = 0; c < 1500; c++) begin
      pause = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 299) == 0);
      ln = ($urandom_range(0, 15) == 0) ? LANE_W'($urandom_range(LANES, 63))
                                        : LANE_W'($urandom_range(0, LANES - 1));
      m  = LANES'({$urandom, $urandom}) & LANES'({$urandom, $urandom}) &
           LANES'({$urandom, $urandom});
      w  = WIDTH'($urandom);
      drive($urandom_range(0, 3) != 0, ln, w, m);
      pause = 1'b0;
      flush = 1'b0;
    end
    step(2 * LANES + 10);
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (exp_q[i].size() != 0);
    check("rand_every_lane_refilled", 64'(avail), 64'(m));
    check("rand_underrun", 64'(underrun), 64'(model_underrun));
    drain();
    check("final_underrun", 64'(underrun), 64'(model_underrun));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
